// File: rtl/pe_mac_seq.sv
// Job sequencer and result collector for one pe_mac processing element: feeds operand pairs,
// waits out the PE pipeline, then returns the raw sum and a rounded, saturated int16.
module pe_mac_seq #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic             aclk_i,
    input  logic             aresetn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [31:0]      cmd_bias_i,
    input  logic [4:0]       cmd_shift_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [15:0]      s_act_i,
    input  logic [7:0]       s_wgt_i,
    output logic             mac_en_o,
    output logic             mac_clear_o,
    output logic [15:0]      mac_a_o,
    output logic [7:0]       mac_w_o,
    output logic [31:0]      mac_bias_o,
    input  logic [31:0]      mac_dout_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [31:0]      m_acc_o,
    output logic [15:0]      m_data_o
);

    localparam int unsigned CntW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StOut} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [31:0]      bias_q, bias_d;
    logic [4:0]       shift_q, shift_d;
    logic             mac_en_q, mac_en_d;
    logic             mac_clear_q, mac_clear_d;
    logic [15:0]      mac_a_q, mac_a_d;
    logic [7:0]       mac_w_q, mac_w_d;
    logic [31:0]      mac_bias_q, mac_bias_d;
    logic             m_valid_q, m_valid_d;
    logic [31:0]      m_acc_q, m_acc_d;
    logic [15:0]      m_data_q, m_data_d;

    logic               cmd_xfer, s_xfer;
    logic signed [32:0] ext, half, sum, rnd;
    logic [15:0]        sat;

    // Gated by reset so that cmd_ready reads 0 while held in reset and 1 right after release.
    assign cmd_ready_o = aresetn_i && (state_q == StIdle);
    assign s_ready_o   = (state_q == StFeed);
    assign cmd_xfer    = cmd_valid_i && cmd_ready_o;
    assign s_xfer      = s_valid_i && s_ready_o;

    // Round half toward +inf in 33 bits so the rounding increment can never overflow.
    always_comb begin
        ext  = {mac_dout_i[31], mac_dout_i};
        half = '0;
        sum  = ext;
        rnd  = ext;
        if (shift_q != 5'd0) begin
            half = 33'sd1 <<< (shift_q - 5'd1);
            sum  = ext + half;
            rnd  = sum >>> shift_q;
        end
        if (rnd > 33'sd32767) begin
            sat = 16'h7fff;
        end else if (rnd < -33'sd32768) begin
            sat = 16'h8000;
        end else begin
            sat = rnd[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        bias_d      = bias_q;
        shift_d     = shift_q;
        mac_en_d    = 1'b0;
        mac_clear_d = 1'b0;
        mac_a_d     = mac_a_q;
        mac_w_d     = mac_w_q;
        mac_bias_d  = mac_bias_q;
        m_valid_d   = m_valid_q;
        m_acc_d     = m_acc_q;
        m_data_d    = m_data_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_xfer) begin
                    bias_d  = cmd_bias_i;
                    shift_d = cmd_shift_i;
                    first_d = 1'b1;
                    if (cmd_len_i != '0) begin
                        rem_d   = cmd_len_i;
                        state_d = StFeed;
                    end else begin
                        // Empty job: a zero pair still clears the PE and loads the bias.
                        mac_en_d    = 1'b1;
                        mac_clear_d = 1'b1;
                        mac_a_d     = '0;
                        mac_w_d     = '0;
                        mac_bias_d  = cmd_bias_i;
                        first_d     = 1'b0;
                        cnt_d       = CntW'(MAC_LAT - 1);
                        state_d     = StDrain;
                    end
                end
            end
            StFeed: begin
                if (s_xfer) begin
                    mac_en_d    = 1'b1;
                    mac_clear_d = first_q;
                    mac_a_d     = s_act_i;
                    mac_w_d     = s_wgt_i;
                    mac_bias_d  = bias_q;
                    first_d     = 1'b0;
                    rem_d       = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        cnt_d   = CntW'(MAC_LAT - 1);
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    m_acc_d   = mac_dout_i;
                    m_data_d  = sat;
                    m_valid_d = 1'b1;
                    state_d   = StOut;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StOut: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            bias_q      <= '0;
            shift_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_a_q     <= '0;
            mac_w_q     <= '0;
            mac_bias_q  <= '0;
            m_valid_q   <= 1'b0;
            m_acc_q     <= '0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            bias_q      <= bias_d;
            shift_q     <= shift_d;
            mac_en_q    <= mac_en_d;
            mac_clear_q <= mac_clear_d;
            mac_a_q     <= mac_a_d;
            mac_w_q     <= mac_w_d;
            mac_bias_q  <= mac_bias_d;
            m_valid_q   <= m_valid_d;
            m_acc_q     <= m_acc_d;
            m_data_q    <= m_data_d;
        end
    end

    assign mac_en_o    = mac_en_q;
    assign mac_clear_o = mac_clear_q;
    assign mac_a_o     = mac_a_q;
    assign mac_w_o     = mac_w_q;
    assign mac_bias_o  = mac_bias_q;
    assign m_valid_o   = m_valid_q;
    assign m_acc_o     = m_acc_q;
    assign m_data_o    = m_data_q;

endmodule

// File: doc/pe_mac_seq.md
# pe_mac_seq

Sequencer and result collector that drives a single `pe_mac` processing element. It accepts one dot-product job per command: length, bias and requantisation shift. It streams the job's activation/weight pairs into the PE and tracks the PE's fixed pipeline latency. When the job completes it captures the 32-bit accumulator and returns both the raw sum and a rounded, saturated int16 activation on a valid/ready result port. It sits between the layer controller and the PE array, one instance per PE column.

## Interface
- `LEN_W`, 16, width of the job length field.
- `MAC_LAT`, 3, number of clock edges from the last-pair accept edge to the edge at which `mac_dout` holds the final sum. The value is fixed by the PE pipeline.
- `aclk`  in  1  clock; all logic rises on the posedge.
- `aresetn`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  job command valid.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_len`  in  LEN_W  number of pairs K; 0 is legal.
- `cmd_bias`  in  32  signed bias loaded into the PE on the first pair.
- `cmd_shift`  in  5  requant right-shift, 0..31.
- `s_valid`  in  1  operand pair valid.
- `s_ready`  out  1  high only in FEED.
- `s_act`  in  16  signed activation.
- `s_wgt`  in  8  signed weight.
- `mac_en`, `mac_clear`  out  1 each  registered PE controls.
- `mac_a`  out  16  registered PE operand.
- `mac_w`  out  8  registered PE operand.
- `mac_bias`  out  32  registered PE operand.
- `mac_dout`  in  32  signed PE accumulator.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result accept.
- `m_acc`  out  32  raw signed accumulator.
- `m_data`  out  16  requantised signed activation.

## Operation
- Handshakes: a transfer occurs on any edge where valid and ready are both high. Valid must not depend on ready. A source may not drop valid before the transfer.
- States: IDLE, FEED, DRAIN, OUT.
- **IDLE**
  - On a cmd transfer, latch len, bias and shift, and set the first flag.
  - If `cmd_len`≠0, go to FEED with `remaining`=K.
  - If `cmd_len`=0, issue a synthetic pair on the same edge (`mac_en`=1, `mac_clear`=1, a=0, w=0, bias=`cmd_bias`), treat that edge as the last-pair accept, and go to DRAIN.
- **FEED**
  - On each s transfer, register `mac_en`=1, `mac_a`=`s_act`, `mac_w`=`s_wgt`, `mac_bias`=latched bias, and `mac_clear`=first flag. Clear the first flag and decrement `remaining`.
  - A cycle with no transfer registers `mac_en`=0 (bubble); the PE holds its sum.
  - The transfer that makes `remaining` reach 0 goes to DRAIN.
- **DRAIN**
  - Registered `mac_en`/`mac_clear` return to 0.
  - A counter loads MAC_LAT−1 on entry.
  - At the edge MAC_LAT edges after the last-pair accept edge:
    - `m_acc` ← `mac_dout`,
    - `m_data` ← sat16(rnd(`mac_dout`, shift)),
    - `m_valid` ← 1,
    - go to OUT.
- **OUT**
  - Outputs are held stable.
  - On an m transfer, `m_valid` ← 0 and go to IDLE.
  - There is no overlap: the next cmd is accepted no earlier than the edge after the m transfer.
- Arithmetic:
  - rnd(x,0)=x.
  - For s>0, rnd(x,s)=(x + 2^(s−1)) >>> s, computed in 33-bit signed (round half toward +inf).
  - sat16 clamps to [−32768, 32767].

## Timing
- Reset value of every output is 0: `cmd_ready`, `s_ready`, `mac_*`, `m_valid`, `m_acc`, `m_data`. Reset returns the state to IDLE, clears `remaining`, the drain counter and the first flag.
- After deassert, `cmd_ready`=1 from the first cycle.
- A reset mid-job abandons the job. `pe_mac` shares `aresetn`. The next job starts with `mac_clear`=1, so no stale sum carries over.
- Operand latency: s transfer at edge E → `mac_en`/data visible cycle after E → PE registers at E+1 → `mac_dout` updated at E+2 → captured at E+3 (MAC_LAT=3).
- Job latency with no bubbles: cmd accept at edge C, first pair accepted at C+1 at the earliest, last at C+K, and `m_valid` rises at C+K+3.
- `s_ready` and `cmd_ready` are registered state decodes, never combinational from `m_ready`.

## Test plan
- K=3, bias=100, shift=0, pairs (10,2), (−5,3), (7,−1), continuous valid → `m_acc`=98, `m_data`=98. `m_valid` rises exactly 3 edges after the third s transfer.
- Saturation: K=1, bias=0, shift=0, (32767,127) → `m_acc`=4161409, `m_data`=32767. Then (−32768,127) → `m_acc`=−4161536, `m_data`=−32768.
- Rounding: K=1, shift=4, bias=0, (24,1) → `m_data`=2. Then (−24,1) → `m_data`=−1. Then (8,1) → 1.
- K=0, bias=−7 → no s transfer, `mac_clear` pulse with a=w=0, `m_acc`=−7, `m_valid` 3 edges after the cmd transfer.
- Bubbles and backpressure: K=4, `s_valid` pattern 1,0,0,1,1,0,1 and `m_ready` low for 5 cycles → sum correct. `mac_en`=0 on bubble cycles. `m_acc`/`m_data` stable while stalled. `cmd_ready`=0 until the cycle after the m transfer.
- Reset mid-FEED after 2 of 5 pairs → all outputs 0 next cycle. A fresh K=2 job (1,1),(2,2), bias=0 then gives `m_acc`=5.
